// File: rtl/csa_pkg.sv
// Shared widths, field offsets and S-box truth tables for the CSA stream-cipher S-box bank.
// Each table is a packed 32-entry array. Entry 0 is the most significant pair.
package csa_pkg;

    localparam int SBOX_IN_W  = 5;
    localparam int SBOX_OUT_W = 2;
    localparam int N_SBOX     = 7;
    localparam int BANK_IN_W  = SBOX_IN_W * N_SBOX;
    localparam int BANK_OUT_W = SBOX_OUT_W * N_SBOX;

    typedef logic [0:31][SBOX_OUT_W-1:0] sbox_tbl_t;

    localparam sbox_tbl_t SBOX_TBL [N_SBOX] = '{
        64'b10_00_01_01_10_11_11_00_11_10_10_00_01_01_00_11_00_11_11_00_10_10_01_01_10_10_00_11_01_01_11_00,
        64'b11_01_00_10_10_11_11_00_01_11_10_01_00_00_01_10_11_01_00_11_11_10_00_10_00_00_01_10_10_01_11_01,
        64'b10_00_01_10_10_11_11_01_01_01_00_11_11_00_10_00_01_11_00_01_11_00_10_10_10_00_01_10_00_11_11_01,
        64'b11_01_10_11_00_10_01_10_01_10_00_01_11_00_00_11_01_00_11_01_10_11_00_11_00_11_10_00_01_10_10_01,
        64'b10_00_00_01_11_10_11_10_00_01_11_11_01_00_10_01_10_11_10_00_00_11_01_01_01_00_11_10_11_01_00_10,
        64'b00_01_10_11_01_10_10_00_00_01_11_00_10_11_01_11_10_11_00_10_11_00_01_01_10_01_01_10_00_11_11_00,
        64'b00_11_10_10_11_00_00_01_11_00_01_11_01_10_10_01_01_00_11_11_00_01_01_10_10_11_01_00_10_11_00_10
    };

    // Field slices for group k: input bits [in_lsb(k) +: 5], output bits [out_lsb(k) +: 2].
    function automatic int in_lsb(input int k);
        return k * SBOX_IN_W;
    endfunction

    function automatic int out_lsb(input int k);
        return k * SBOX_OUT_W;
    endfunction

endpackage

// File: rtl/csa_sbox_bank.sv
// Combinational bank of the seven CSA stream-cipher S-boxes.
// Group k of the 35-bit input feeds sbox(k+1).
module csa_sbox_bank
    import csa_pkg::*;
(
    input  logic [BANK_IN_W-1:0]  bank_in,
    output logic [BANK_OUT_W-1:0] bank_out
);

    for (genvar gi = 0; gi < N_SBOX; gi++) begin : g_sbox
        assign bank_out[out_lsb(gi) +: SBOX_OUT_W] =
            SBOX_TBL[gi][bank_in[in_lsb(gi) +: SBOX_IN_W]];
    end

endmodule

// File: rtl/csa_sbox_arbiter.sv
// Round-robin arbiter that shares one CSA S-box bank between N_REQ requesters.
// The result is held in a one-entry response register with backpressure.
module csa_sbox_arbiter
    import csa_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int IDW   = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [N_REQ-1:0]           req_valid,
    input  logic [BANK_IN_W*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]           req_ready,
    output logic                       rsp_valid,
    input  logic                       rsp_ready,
    output logic [IDW-1:0]             rsp_id,
    output logic [BANK_OUT_W-1:0]      rsp_data
);

    localparam int PTR_W = $clog2(N_REQ);

    logic [PTR_W-1:0]      rr_ptr_q, rr_ptr_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [IDW-1:0]        rsp_id_q, rsp_id_d;
    logic [BANK_OUT_W-1:0] rsp_data_q, rsp_data_d;

    logic                  grant_found;
    logic [PTR_W-1:0]      grant_idx;
    logic [PTR_W-1:0]      cand;
    logic                  can_accept;
    logic                  accept;
    logic [BANK_IN_W-1:0]  req_word [N_REQ];
    logic [BANK_IN_W-1:0]  bank_in;
    logic [BANK_OUT_W-1:0] bank_out;

    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_word
        assign req_word[gi] = req_data[gi*BANK_IN_W +: BANK_IN_W];
    end

    // Search starts just after the last winner.
    always_comb begin
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int off = 1; off <= N_REQ; off++) begin
            cand = PTR_W'((int'(rr_ptr_q) + off) % N_REQ);
            if (!grant_found && req_valid[cand]) begin
                grant_found = 1'b1;
                grant_idx   = cand;
            end
        end
    end

    // A register that drains this cycle can be refilled in the same cycle.
    assign can_accept = !rsp_valid_q || rsp_ready;
    assign accept     = grant_found && can_accept;
    assign bank_in    = req_word[grant_idx];

    csa_sbox_bank u_bank (
        .bank_in  (bank_in),
        .bank_out (bank_out)
    );

    always_comb begin
        rr_ptr_d    = rr_ptr_q;
        rsp_valid_d = rsp_valid_q;
        rsp_id_d    = rsp_id_q;
        rsp_data_d  = rsp_data_q;
        if (accept) begin
            rr_ptr_d    = grant_idx;
            rsp_valid_d = 1'b1;
            rsp_id_d    = IDW'(grant_idx);
            rsp_data_d  = bank_out;
        end else if (rsp_ready) begin
            rsp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q    <= PTR_W'(N_REQ - 1);
            rsp_valid_q <= 1'b0;
            rsp_id_q    <= '0;
            rsp_data_q  <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_id_q    <= rsp_id_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    // The ready gate on rst_n keeps requesters off the bus while reset is held.
    for (genvar gi = 0; gi < N_REQ; gi++) begin : g_ready
        assign req_ready[gi] = rst_n && accept && (grant_idx == PTR_W'(gi));
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;

endmodule

// File: tb/tb_csa_sbox_arbiter.sv
// Scoreboard bench for csa_sbox_arbiter: accepted lookups push the expected response,
// and each response is popped and compared when it appears.
module tb_csa_sbox_arbiter;

    localparam int N_REQ = 4;
    localparam int IDW   = 2;

    logic                 clk       = 1'b0;
    logic                 rst_n     = 1'b0;
    logic [N_REQ-1:0]     req_valid = '0;
    logic [35*N_REQ-1:0]  req_data  = '0;
    logic [N_REQ-1:0]     req_ready;
    logic                 rsp_valid;
    logic                 rsp_ready = 1'b0;
    logic [IDW-1:0]       rsp_id;
    logic [13:0]          rsp_data;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [IDW-1:0] id;
        logic [13:0]    data;
    } exp_t;

    exp_t sb_q[$];

    // CSA stream-cipher S-box tables, sbox1..sbox7.
    int sb_tbl [7][32] = '{
        '{2,0,1,1,2,3,3,0, 3,2,2,0,1,1,0,3, 0,3,3,0,2,2,1,1, 2,2,0,3,1,1,3,0},
        '{3,1,0,2,2,3,3,0, 1,3,2,1,0,0,1,2, 3,1,0,3,3,2,0,2, 0,0,1,2,2,1,3,1},
        '{2,0,1,2,2,3,3,1, 1,1,0,3,3,0,2,0, 1,3,0,1,3,0,2,2, 2,0,1,2,0,3,3,1},
        '{3,1,2,3,0,2,1,2, 1,2,0,1,3,0,0,3, 1,0,3,1,2,3,0,3, 0,3,2,0,1,2,2,1},
        '{2,0,0,1,3,2,3,2, 0,1,3,3,1,0,2,1, 2,3,2,0,0,3,1,1, 1,0,3,2,3,1,0,2},
        '{0,1,2,3,1,2,2,0, 0,1,3,0,2,3,1,3, 2,3,0,2,3,0,1,1, 2,1,1,2,0,3,3,0},
        '{0,3,2,2,3,0,0,1, 3,0,1,3,1,2,2,1, 1,0,3,3,0,1,1,2, 2,3,1,0,2,3,0,2}
    };

    csa_sbox_arbiter #(.N_REQ(N_REQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data)
    );

    always #5 clk = ~clk;

    function automatic logic [13:0] model(input logic [34:0] w);
        logic [13:0] r;
        r = '0;
        for (int k = 0; k < 7; k++) begin
            r[2*k +: 2] = 2'(sb_tbl[k][w[5*k +: 5]]);
        end
        return r;
    endfunction

    function automatic logic [34:0] get_word(input int i);
        return req_data[35*i +: 35];
    endfunction

    task automatic set_word(input int i, input logic [34:0] w);
        req_data[35*i +: 35] = w;
    endtask

    function automatic logic [34:0] rand_word();
        return 35'({$urandom(), $urandom()});
    endfunction

    task automatic push_exp(input int idx);
        exp_t e;
        e.id   = IDW'(idx);
        e.data = model(get_word(idx));
        sb_q.push_back(e);
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst_n = 1'b0;
        req_valid = '0;
        @(negedge clk);
        rst_n = 1'b1;
        sb_q.delete();
    endtask

    task automatic test_reset();
        exp_t e;
        rst_n = 1'b0;
        rsp_ready = 1'b1;
        req_valid = '1;
        for (int i = 0; i < N_REQ; i++) set_word(i, rand_word());
        @(negedge clk);
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || rsp_id !== '0 || rsp_data !== '0) begin
            failures++;
            $display("FAIL reset_state: valid=%0b id=%0d data=%h required 0/0/0", rsp_valid, rsp_id, rsp_data);
        end
        checks++;
        if (req_ready !== 4'b0000) begin
            failures++;
            $display("FAIL reset_ready: got=%b required=0000", req_ready);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0001) begin
            failures++;
            $display("FAIL reset_first_grant: got=%b required=0001", req_ready);
        end
        push_exp(0);
        @(negedge clk);
        e = sb_q.pop_front();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== e.id || rsp_data !== e.data) begin
            failures++;
            $display("FAIL reset_first_rsp: valid=%0b id=%0d data=%h required 1/%0d/%h", rsp_valid, rsp_id, rsp_data, e.id, e.data);
        end
        $display("txn reset first grant id=%0d data=%h", rsp_id, rsp_data);
        rsp_ready = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || req_ready !== 4'b0000 || rsp_id !== '0 || rsp_data !== '0) begin
            failures++;
            $display("FAIL reset_mid: valid=%0b ready=%b id=%0d data=%h required 0/0000/0/0", rsp_valid, req_ready, rsp_id, rsp_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b1;
        sb_q.delete();
    endtask

    task automatic test_single();
        exp_t e;
        @(negedge clk);
        set_word(1, 35'h0);
        req_valid = 4'b0010;
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b0010) begin
            failures++;
            $display("FAIL single_ready: got=%b required=0010", req_ready);
        end
        push_exp(1);
        @(negedge clk);
        req_valid = '0;
        e = sb_q.pop_front();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== e.id || rsp_data !== e.data) begin
            failures++;
            $display("FAIL single_rsp: valid=%0b id=%0d data=%h required 1/%0d/%h", rsp_valid, rsp_id, rsp_data, e.id, e.data);
        end
        checks++;
        if (rsp_data[3:2] !== 2'h3) begin
            failures++;
            $display("FAIL single_sbox2: got=%h required=3", rsp_data[3:2]);
        end
        $display("txn single id=%0d data=%h", rsp_id, rsp_data);
        @(negedge clk);
        checks++;
        if (rsp_valid !== 1'b0) begin
            failures++;
            $display("FAIL single_drain: valid=%0b required=0", rsp_valid);
        end
    endtask

    task automatic test_field();
        exp_t e;
        logic [4:0] grp [2];
        logic [1:0] fld [2];
        grp = '{5'h02, 5'h1f};
        fld = '{2'h0, 2'h1};
        rsp_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                checks++;
                if (rsp_valid !== 1'b1 || rsp_id !== e.id || rsp_data !== e.data || rsp_data[3:2] !== fld[c-1]) begin
                    failures++;
                    $display("FAIL field_rsp: valid=%0b id=%0d data=%h required 1/%0d/%h (group1 %h)", rsp_valid, rsp_id, rsp_data, e.id, e.data, fld[c-1]);
                end
                $display("txn field id=%0d data=%h", rsp_id, rsp_data);
            end
            if (c < 2) begin
                set_word(0, {25'h0, grp[c], 5'h0});
                req_valid = 4'b0001;
                #1;
                checks++;
                if (req_ready !== 4'b0001) begin
                    failures++;
                    $display("FAIL field_ready: got=%b required=0001", req_ready);
                end
                push_exp(0);
            end else begin
                req_valid = '0;
            end
        end
    endtask

    task automatic test_round_robin();
        exp_t e;
        int order [6];
        order = '{0, 1, 2, 3, 0, 1};
        apply_reset();
        rsp_ready = 1'b1;
        for (int i = 0; i < N_REQ; i++) set_word(i, rand_word());
        for (int c = 0; c < 7; c++) begin
            @(negedge clk);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                checks++;
                if (rsp_valid !== 1'b1 || rsp_id !== e.id || rsp_data !== e.data) begin
                    failures++;
                    $display("FAIL rr_rsp: valid=%0b id=%0d data=%h required 1/%0d/%h", rsp_valid, rsp_id, rsp_data, e.id, e.data);
                end
                $display("txn rr id=%0d data=%h", rsp_id, rsp_data);
            end
            if (c > 0) set_word(order[c-1], rand_word());
            if (c < 6) begin
                req_valid = '1;
                #1;
                checks++;
                if (req_ready !== 4'(1 << order[c])) begin
                    failures++;
                    $display("FAIL rr_grant: cycle=%0d got=%b required=%b", c, req_ready, 4'(1 << order[c]));
                end
                push_exp(order[c]);
            end else begin
                req_valid = '0;
            end
        end
    endtask

    task automatic test_backpressure();
        exp_t e;
        exp_t held;
        @(negedge clk);
        rsp_ready = 1'b1;
        req_valid = '1;
        #1;
        checks++;
        if (req_ready !== 4'b0100) begin
            failures++;
            $display("FAIL bp_first_grant: got=%b required=0100", req_ready);
        end
        push_exp(2);
        @(negedge clk);
        held = sb_q.pop_front();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== held.id || rsp_data !== held.data) begin
            failures++;
            $display("FAIL bp_first_rsp: valid=%0b id=%0d data=%h required 1/%0d/%h", rsp_valid, rsp_id, rsp_data, held.id, held.data);
        end
        rsp_ready = 1'b0;
        set_word(2, rand_word());
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if (req_ready !== 4'b0000 || rsp_valid !== 1'b1 || rsp_id !== held.id || rsp_data !== held.data) begin
                failures++;
                $display("FAIL bp_hold: cycle=%0d ready=%b valid=%0b id=%0d data=%h required 0000/1/%0d/%h", i, req_ready, rsp_valid, rsp_id, rsp_data, held.id, held.data);
            end
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 4'b1000 || rsp_valid !== 1'b1 || rsp_id !== held.id) begin
            failures++;
            $display("FAIL bp_release: ready=%b valid=%0b id=%0d required 1000/1/%0d", req_ready, rsp_valid, rsp_id, held.id);
        end
        push_exp(3);
        $display("txn backpressure held id=%0d data=%h", held.id, held.data);
        @(negedge clk);
        req_valid = '0;
        e = sb_q.pop_front();
        checks++;
        if (rsp_valid !== 1'b1 || rsp_id !== e.id || rsp_data !== e.data) begin
            failures++;
            $display("FAIL bp_next_rsp: valid=%0b id=%0d data=%h required 1/%0d/%h", rsp_valid, rsp_id, rsp_data, e.id, e.data);
        end
        $display("txn backpressure next id=%0d data=%h", rsp_id, rsp_data);
        @(negedge clk);
    endtask

    task automatic test_sparse();
        exp_t e;
        logic [3:0] vld [3];
        int win [3];
        vld = '{4'b1000, 4'b1001, 4'b1000};
        win = '{3, 0, 3};
        rsp_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                checks++;
                if (rsp_valid !== 1'b1 || rsp_id !== e.id || rsp_data !== e.data) begin
                    failures++;
                    $display("FAIL sparse_rsp: valid=%0b id=%0d data=%h required 1/%0d/%h", rsp_valid, rsp_id, rsp_data, e.id, e.data);
                end
                $display("txn sparse id=%0d data=%h", rsp_id, rsp_data);
                set_word(win[c-1], rand_word());
            end
            if (c < 3) begin
                req_valid = vld[c];
                #1;
                checks++;
                if (req_ready !== 4'(1 << win[c])) begin
                    failures++;
                    $display("FAIL sparse_grant: step=%0d got=%b required=%b", c, req_ready, 4'(1 << win[c]));
                end
                push_exp(win[c]);
            end else begin
                req_valid = '0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_field();
        test_round_robin();
        test_backpressure();
        test_sparse();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

endmodule
